// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: issues load, ITERS step cycles,
// then a one-cycle result-ready pulse with exception status.
module multdiv_ctrl #(
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             load,
    output logic             step,
    output logic             op_div,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             dz_latched;
    logic             start;

    assign start = ctrl_MULT | ctrl_DIV;

    // A start pulse wins in every state, so a restart silently abandons the op in flight.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            op_div     <= 1'b0;
            dz_latched <= 1'b0;
        end else if (start) begin
            state  <= INIT;
            count  <= '0;
            op_div <= ctrl_DIV & ~ctrl_MULT;
        end else begin
            case (state)
                IDLE: count <= '0;
                INIT: begin
                    count      <= '0;
                    dz_latched <= op_div & divisor_zero;
                    state      <= (op_div & divisor_zero) ? DONE : RUN;
                end
                RUN: begin
                    if (count == LAST_STEP) begin
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs; mult_ovf is only meaningful while the datapath holds the final product.
    assign load           = (state == INIT);
    assign step           = (state == RUN);
    assign busy           = (state == INIT) || (state == RUN);
    assign data_resultRDY = (state == DONE);
    assign data_exception = (state == DONE) && (op_div ? dz_latched : mult_ovf);
    assign step_count     = (state == RUN) ? count : '0;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: reset, multiply, divide-by-zero, abort, dual start, back-to-back.
module tb_multdiv_ctrl;

    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    logic             clk;
    logic             reset;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             divisor_zero;
    logic             mult_ovf;
    logic             load;
    logic             step;
    logic             op_div;
    logic [CNT_W-1:0] step_count;
    logic             busy;
    logic             data_resultRDY;
    logic             data_exception;

    int n_cmp = 0;
    int n_err = 0;

    // {load, step, busy, data_resultRDY, data_exception}
    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_LOAD = 5'b10100;
    localparam logic [4:0] V_STEP = 5'b01100;
    localparam logic [4:0] V_RDY0 = 5'b00010;
    localparam logic [4:0] V_RDY1 = 5'b00011;

    multdiv_ctrl #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .divisor_zero   (divisor_zero),
        .mult_ovf       (mult_ovf),
        .load           (load),
        .step           (step),
        .op_div         (op_div),
        .step_count     (step_count),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] vec();
        return {load, step, busy, data_resultRDY, data_exception};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one cycle after the start edge (the load cycle); returns in the ready cycle.
    task automatic run_and_check_op(input string name, input logic exp_div, input logic exp_exc);
        n_cmp++;
        if (vec() !== V_LOAD || op_div !== exp_div) begin
            n_err++;
            $display("FAIL %s load: vec=%b op_div=%b want vec=%b op_div=%b", name, vec(), op_div, V_LOAD, exp_div);
        end
        for (int i = 0; i < ITERS; i++) begin
            tick();
            n_cmp++;
            if (vec() !== V_STEP || step_count !== CNT_W'(i)) begin
                n_err++;
                $display("FAIL %s step %0d: vec=%b step_count=%0d want vec=%b step_count=%0d",
                         name, i, vec(), step_count, V_STEP, i);
            end
        end
        tick();
        n_cmp++;
        if (vec() !== (exp_exc ? V_RDY1 : V_RDY0) || op_div !== exp_div || step_count !== '0) begin
            n_err++;
            $display("FAIL %s ready: vec=%b op_div=%b step_count=%0d want vec=%b op_div=%b step_count=0",
                     name, vec(), op_div, step_count, exp_exc ? V_RDY1 : V_RDY0, exp_div);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (vec() !== V_IDLE || op_div !== 1'b0 || step_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: vec=%b op_div=%b step_count=%0d want all 0", vec(), op_div, step_count);
        end
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (vec() !== V_IDLE) begin
            n_err++;
            $display("FAIL reset_release_idle: vec=%b want %b", vec(), V_IDLE);
        end
    endtask

    task automatic test_mult();
        mult_ovf  = 1'b0;
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        run_and_check_op("mult", 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (vec() !== V_IDLE || op_div !== 1'b0) begin
            n_err++;
            $display("FAIL mult_after_idle: vec=%b op_div=%b want %b op_div=0", vec(), op_div, V_IDLE);
        end
    endtask

    task automatic test_div_zero();
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b1;
        n_cmp++;
        if (vec() !== V_LOAD || op_div !== 1'b1) begin
            n_err++;
            $display("FAIL dz_load: vec=%b op_div=%b want %b op_div=1", vec(), op_div, V_LOAD);
        end
        tick();
        divisor_zero = 1'b0;
        n_cmp++;
        if (vec() !== V_RDY1 || op_div !== 1'b1) begin
            n_err++;
            $display("FAIL dz_ready: vec=%b op_div=%b want %b op_div=1", vec(), op_div, V_RDY1);
        end
        tick();
        n_cmp++;
        if (vec() !== V_IDLE || op_div !== 1'b1) begin
            n_err++;
            $display("FAIL dz_idle: vec=%b op_div=%b want %b op_div=1", vec(), op_div, V_IDLE);
        end
    endtask

    task automatic test_abort();
        mult_ovf  = 1'b1;
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int i = 0; i <= 10; i++) tick();
        n_cmp++;
        if (vec() !== V_STEP || step_count !== CNT_W'(10)) begin
            n_err++;
            $display("FAIL abort_pre: vec=%b step_count=%0d want %b step_count=10", vec(), step_count, V_STEP);
        end
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        run_and_check_op("abort_div", 1'b1, 1'b0);
        mult_ovf = 1'b0;
        tick();
    endtask

    task automatic test_both_start();
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        tick();
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b1;
        mult_ovf     = 1'b1;
        run_and_check_op("both", 1'b0, 1'b1);
        divisor_zero = 1'b0;
        mult_ovf     = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        run_and_check_op("b2b_first", 1'b0, 1'b0);
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        run_and_check_op("b2b_second", 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (vec() !== V_IDLE) begin
            n_err++;
            $display("FAIL b2b_idle: vec=%b want %b", vec(), V_IDLE);
        end
    endtask

    task automatic test_reset_mid_run();
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int i = 0; i <= 17; i++) tick();
        n_cmp++;
        if (vec() !== V_STEP || step_count !== CNT_W'(17)) begin
            n_err++;
            $display("FAIL rst_pre: vec=%b step_count=%0d want %b step_count=17", vec(), step_count, V_STEP);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (vec() !== V_IDLE || op_div !== 1'b0 || step_count !== '0) begin
            n_err++;
            $display("FAIL rst_async: vec=%b op_div=%b step_count=%0d want all 0", vec(), op_div, step_count);
        end
        ctrl_DIV = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (vec() !== V_IDLE || op_div !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ignore_start: vec=%b op_div=%b want all 0", vec(), op_div);
        end
        ctrl_DIV = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (vec() !== V_IDLE) begin
                n_err++;
                $display("FAIL rst_release cycle %0d: vec=%b want %b", i, vec(), V_IDLE);
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b0;
        mult_ovf     = 1'b0;
        test_reset();
        test_mult();
        test_div_zero();
        test_abort();
        test_both_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
